lc3_mem_if: RTL and testbench
=============================

Name: lc3_mem_if

Overview:
- Memory-interface stage directly downstream of the LC-3 address-select adder.
- Holds MAR and MDR and runs single-outstanding read/write handshakes to the external memory.
- Returns a one-cycle ready pulse (R) to the control FSM.
- MAR is loaded from the effective address the adder produces, gated through the bus.

Parameters:
- ADDR_W, 16, address width (MAR, mem_addr).
- DATA_W, 16, data width (MDR, bus, memory data).
- TIMEOUT_CYCLES, 64, ACCESS cycles before abort; used only when LC3_MEM_TIMEOUT_EN is defined; must be ≥1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr_in  in  ADDR_W  effective address (adder output via bus).
- bus_in  in  DATA_W  datapath bus, MDR write source.
- ld_mar  in  1  load MAR.
- ld_mdr  in  1  load MDR from bus_in (non-memory load).
- mio_en  in  1  start memory access.
- r_w  in  1  1=write, 0=read; sampled at access start.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion strobe.
- mar  out  ADDR_W  MAR contents.
- mdr  out  DATA_W  MDR contents (drives gate_mdr).
- mem_addr  out  ADDR_W  = mar, registered.
- mem_wdata  out  DATA_W  = mdr.
- mem_req  out  1  access in progress, registered.
- mem_we  out  1  write qualifier, valid only while mem_req=1.
- r  out  1  one-cycle completion pulse to control FSM.
- err  out  1  one-cycle abort pulse, coincident with r.

Behaviour:
- Reset (synchronous; dominates every other input): state=IDLE; mar, mdr=0; mem_req, mem_we, r, err=0; timeout counter=0.
- State machine states: IDLE, ACCESS, DONE.
- IDLE, ld_mar=1: mar <= addr_in.
- IDLE, ld_mdr=1 and mio_en=0: mdr <= bus_in.
- IDLE, mio_en=1:
  - Access address = ld_mar ? addr_in : mar (bypass); mar is also written if ld_mar=1.
  - mem_we <= r_w.
  - For a write, if ld_mdr=1 in the same cycle, mdr <= bus_in first and mem_wdata carries the new value.
  - mem_req <= 1; next state ACCESS.
- ACCESS:
  - mem_req=1; mar and mdr frozen; ld_mar and ld_mdr ignored.
  - mem_ready=1, read: mdr <= mem_rdata. Read or write: mem_req <= 0, mem_we <= 0; next state DONE.
  - mem_ready=0: remain in ACCESS (wait states are unbounded unless the timeout feature is compiled in).
- DONE: r=1 for exactly this cycle; next state IDLE unconditionally. mio_en is ignored in DONE.
- mio_en still high in IDLE after DONE starts a new access; the control FSM is responsible for dropping it.
- mem_ready while in IDLE or DONE is ignored.
- Latency: mio_en in cycle 0; mem_req high from cycle 1; with mem_ready in cycle 1, r=1 in cycle 2 and the new MDR is visible in cycle 2. Each cycle of mem_ready delay adds one cycle.
- Reset in ACCESS or DONE: next cycle is IDLE with all outputs at reset values; no r pulse is issued.
- mar and mem_addr wrap naturally at ADDR_W; no range checks.

Optional Feature:
- Macro: LC3_MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
  - The cycle in which the count reaches TIMEOUT_CYCLES-1 without mem_ready: mem_req <= 0, next state DONE.
  - That DONE cycle: r=1 and err=1.
  - On an aborted read, mdr <= 0. On an aborted write, mdr is unchanged.
  - mem_ready in the same cycle as the timeout takes priority: normal completion, err=0.
- Undefined: no counter; err tied to 0; ACCESS waits indefinitely.

Test Plan:
- Reset with mio_en=1, ld_mar=1 → mar=0, mdr=0, mem_req=0, r=0, err=0 on the cycle after reset.
- Read, zero wait:
  - ld_mar with addr_in=16'h3000, then mio_en=1, r_w=0.
  - mem_ready=1 with mem_rdata=16'h1234 in the first ACCESS cycle.
  - Expect mem_addr=16'h3000, mem_we=0 in ACCESS; r=1 exactly 2 cycles after mio_en; mdr=16'h1234.
- Write with 3 wait states: ld_mdr bus_in=16'hBEEF, then mio_en=1, r_w=1, ld_mar addr_in=16'hFE06 in the same cycle → mem_addr=16'hFE06, mem_we=1, mem_wdata=16'hBEEF for 4 cycles; r=1 for one cycle after; mdr unchanged.
- ld_mar=1 with addr_in=16'h4000 and ld_mdr=1 during ACCESS → mar and mdr unchanged; access completes normally.
- Reset asserted during the second ACCESS cycle → mem_req=0 next cycle, no r pulse, state IDLE.
- LC3_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, read with mem_ready never asserted → mem_req high 4 cycles; then r=1, err=1 for one cycle; mdr=0.

Source files
------------

// File: rtl/lc3_mem_if.sv
// lc3_mem_if -- LC-3 memory interface stage (MAR/MDR + memory handshake).
//
// Sits downstream of the address-select adder. Holds MAR and MDR and runs one
// outstanding read or write at a time against an external memory, answering
// the control FSM with a single-cycle ready pulse (r).
//
// Optional feature: define LC3_MEM_TIMEOUT_EN to abort an access that has not
// seen mem_ready within TIMEOUT_CYCLES cycles (r and err pulse together).
//
// Ports:
//   clk, reset   single rising-edge clock, synchronous active-high reset
//   addr_in      effective address from the adder (via bus)
//   bus_in       datapath bus, MDR load source
//   ld_mar       load MAR (idle only)
//   ld_mdr       load MDR from bus_in (idle only)
//   mio_en       start a memory access
//   r_w          1 = write, 0 = read, sampled at access start
//   mem_rdata    memory read data, valid with mem_ready
//   mem_ready    memory completion strobe
//   mar, mdr     register contents
//   mem_addr     registered copy of MAR presented to memory
//   mem_wdata    write data (= mdr)
//   mem_req      access in progress
//   mem_we       write qualifier, meaningful only while mem_req = 1
//   r            one-cycle completion pulse
//   err          one-cycle abort pulse, coincident with r
module lc3_mem_if #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              ld_mar,
   input  logic              ld_mdr,
   input  logic              mio_en,
   input  logic              r_w,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mar,
   output logic [DATA_W-1:0] mdr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic              r,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] mar_nxt;
   logic [DATA_W-1:0] mdr_nxt;
   logic              req_nxt;
   logic              we_nxt;
   logic              abort_nxt;

`ifdef LC3_MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             timeout_hit;
   assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   // Parameter kept in the interface for build compatibility only.
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT_CYCLES < 1);
`endif

   // Write data always reflects MDR; r is simply "in DONE".
   assign mem_wdata = mdr;
   assign r         = (state == DONE);

   always_comb begin
      state_nxt = state;
      mar_nxt   = mar;
      mdr_nxt   = mdr;
      req_nxt   = mem_req;
      we_nxt    = mem_we;
      abort_nxt = 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
      cnt_nxt   = cnt;
`endif
      case (state)
         IDLE: begin
            if (ld_mar) mar_nxt = addr_in;
            // A read launched this cycle overwrites MDR on completion, so the
            // bus load is only honoured when no access starts or for a write.
            if (ld_mdr && (!mio_en || r_w)) mdr_nxt = bus_in;
            if (mio_en) begin
               req_nxt   = 1'b1;
               we_nxt    = r_w;
               state_nxt = ACCESS;
`ifdef LC3_MEM_TIMEOUT_EN
               cnt_nxt   = '0;
`endif
            end
         end
         ACCESS: begin
            if (mem_ready) begin
               if (!mem_we) mdr_nxt = mem_rdata;
               req_nxt   = 1'b0;
               we_nxt    = 1'b0;
               state_nxt = DONE;
            end
`ifdef LC3_MEM_TIMEOUT_EN
            else if (timeout_hit) begin
               if (!mem_we) mdr_nxt = '0;
               req_nxt   = 1'b0;
               we_nxt    = 1'b0;
               abort_nxt = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
`endif
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
            we_nxt    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         mar      <= '0;
         mdr      <= '0;
         mem_addr <= '0;
         mem_req  <= 1'b0;
         mem_we   <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         mar      <= mar_nxt;
         mdr      <= mdr_nxt;
         // mem_addr tracks MAR exactly, giving the ld_mar bypass at access start.
         mem_addr <= mar_nxt;
         mem_req  <= req_nxt;
         mem_we   <= we_nxt;
         err      <= abort_nxt;
      end
   end

`ifdef LC3_MEM_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else       cnt <= cnt_nxt;
   end
`endif

endmodule

// File: tb/tb_lc3_mem_if.sv
module tb_lc3_mem_if;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 4;

`ifdef LC3_MEM_TIMEOUT_EN
   localparam bit HAS_TO = 1'b1;
`else
   localparam bit HAS_TO = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] addr_in = '0;
   logic [DW-1:0] bus_in = '0;
   logic          ld_mar = 1'b0;
   logic          ld_mdr = 1'b0;
   logic          mio_en = 1'b0;
   logic          r_w = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;
   logic [AW-1:0] mar, mem_addr;
   logic [DW-1:0] mdr, mem_wdata;
   logic          mem_req, mem_we, r, err;

   int tests = 0;
   int fails = 0;

   // Reference model: architectural MAR/MDR contents.
   logic [AW-1:0] m_mar = '0;
   logic [DW-1:0] m_mdr = '0;

   always #5 clk = ~clk;

   lc3_mem_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .addr_in(addr_in), .bus_in(bus_in),
      .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en), .r_w(r_w),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mar(mar), .mdr(mdr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .r(r), .err(err)
   );

   task automatic idle_inputs();
      mio_en = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0; r_w = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; mio_en = 1'b1; ld_mar = 1'b1; ld_mdr = 1'b1;
      addr_in = 16'h5A5A; bus_in = 16'hA5A5; r_w = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      tests++;
      if ({mar, mdr, mem_addr, mem_req, mem_we, r, err} !== {16'h0, 16'h0, 16'h0, 4'b0000}) begin
         fails++;
         $display("FAIL reset mar=%h mdr=%h addr=%h req/we/r/err=%b%b%b%b want all zero",
                  mar, mdr, mem_addr, mem_req, mem_we, r, err);
      end
      reset = 1'b0;
      idle_inputs();
      m_mar = '0; m_mdr = '0;
      @(negedge clk);
      tests++;
      if ({mem_req, r, err} !== 3'b000) begin
         fails++;
         $display("FAIL reset_release req/r/err=%b%b%b want 000", mem_req, r, err);
      end
   endtask

   // Random MAR/MDR loads with no access; call at a negedge.
   task automatic test_idle_loads(input int n);
      logic lm, ld;
      logic [15:0] a, d;
      for (int i = 0; i < n; i++) begin
         lm = 1'($urandom); ld = 1'($urandom); a = 16'($urandom); d = 16'($urandom);
         ld_mar = lm; addr_in = a; ld_mdr = ld; bus_in = d; mio_en = 1'b0;
         @(negedge clk);
         if (lm) m_mar = a;
         if (ld) m_mdr = d;
         tests++;
         if ({mar, mem_addr, mdr, mem_req, r, err} !== {m_mar, m_mar, m_mdr, 3'b000}) begin
            fails++;
            $display("FAIL idle_load mar=%h addr=%h mdr=%h req/r/err=%b%b%b want mar=%h mdr=%h 000",
                     mar, mem_addr, mdr, mem_req, r, err, m_mar, m_mdr);
         end
      end
      idle_inputs();
   endtask

   // One full access; waits = cycles of mem_ready delay. Call at a negedge with DUT idle.
   task automatic do_access(input logic wr, input logic use_lm, input logic [15:0] a,
                            input logic use_ld, input logic [15:0] d,
                            input int waits, input logic [15:0] rd);
      logic          abort;
      int            n_acc;
      logic [15:0]   exp_wdata;
      abort = HAS_TO && (waits >= TO);
      n_acc = abort ? TO : waits + 1;
      mio_en = 1'b1; r_w = wr; ld_mar = use_lm; addr_in = a; ld_mdr = use_ld; bus_in = d;
      if (use_lm) m_mar = a;
      if (wr && use_ld) m_mdr = d;
      exp_wdata = m_mdr;
      for (int i = 0; i < n_acc; i++) begin
         @(negedge clk);
         tests++;
         if ({mem_req, mem_we, mem_addr, mem_wdata, mar, r, err} !==
             {1'b1, wr, m_mar, exp_wdata, m_mar, 2'b00}) begin
            fails++;
            $display("FAIL access_cyc%0d req=%b we=%b addr=%h wdata=%h mar=%h r=%b err=%b want req=1 we=%b addr=%h wdata=%h",
                     i, mem_req, mem_we, mem_addr, mem_wdata, mar, r, err, wr, m_mar, exp_wdata);
         end
         // Loads during the access must be ignored.
         mio_en = 1'b0; ld_mar = 1'b1; ld_mdr = 1'b1;
         addr_in = 16'h4000 ^ 16'($urandom); bus_in = 16'($urandom);
         mem_ready = !abort && (i == waits);
         mem_rdata = mem_ready ? rd : 16'($urandom);
      end
      @(negedge clk);
      if (!wr) m_mdr = abort ? 16'h0 : rd;
      tests++;
      if ({r, err, mem_req, mar, mdr} !== {1'b1, abort, 1'b0, m_mar, m_mdr}) begin
         fails++;
         $display("FAIL done r=%b err=%b req=%b mar=%h mdr=%h want r=1 err=%b req=0 mar=%h mdr=%h",
                  r, err, mem_req, mar, mdr, abort, m_mar, m_mdr);
      end
      idle_inputs();
      @(negedge clk);
      tests++;
      if ({r, err, mem_req, mdr} !== {3'b000, m_mdr}) begin
         fails++;
         $display("FAIL after_done r=%b err=%b req=%b mdr=%h want 000 mdr=%h", r, err, mem_req, mdr, m_mdr);
      end
   endtask

   task automatic test_read_zero_wait();
      ld_mar = 1'b1; addr_in = 16'h3000;
      @(negedge clk);
      m_mar = 16'h3000;
      idle_inputs();
      do_access(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 0, 16'h1234);
   endtask

   task automatic test_write_waits();
      ld_mdr = 1'b1; bus_in = 16'hBEEF;
      @(negedge clk);
      m_mdr = 16'hBEEF;
      idle_inputs();
      do_access(1'b1, 1'b1, 16'hFE06, 1'b0, 16'h0, 3, 16'h0);
   endtask

   task automatic test_write_bypass();
      do_access(1'b1, 1'b1, 16'hFFFF, 1'b1, 16'hC0DE, 1, 16'h0);
   endtask

   task automatic test_reset_in_access();
      mio_en = 1'b1; r_w = 1'b0; ld_mar = 1'b1; addr_in = 16'h1111;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_mar = '0; m_mdr = '0;
      tests++;
      if ({mem_req, r, err, mar, mdr} !== {3'b000, 16'h0, 16'h0}) begin
         fails++;
         $display("FAIL reset_access req=%b r=%b err=%b mar=%h mdr=%h want 000 0 0",
                  mem_req, r, err, mar, mdr);
      end
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b1;
         @(negedge clk);
         tests++;
         if ({mem_req, r, err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_access_idle%0d req=%b r=%b err=%b want 000", i, mem_req, r, err);
         end
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_timeout();
      do_access(1'b0, 1'b1, 16'h2222, 1'b0, 16'h0, TO + 5, 16'h0);
      do_access(1'b1, 1'b1, 16'h3333, 1'b1, 16'h7777, TO + 1, 16'h0);
      do_access(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, TO - 1, 16'h9ABC);
   endtask

   task automatic test_random(input int n);
      for (int k = 0; k < n; k++) begin
         test_idle_loads(int'($urandom_range(0, 2)));
         do_access(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
                   int'($urandom_range(0, 6)), 16'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_idle_loads(6);
      test_read_zero_wait();
      test_write_waits();
      test_write_bypass();
      test_reset_in_access();
      test_timeout();
      test_random(40);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
